// File: rtl/wb_master_arbiter_if.sv
// rtl/wb_master_arbiter_if.sv - Wishbone signal bundle for the two-master arbiter
interface wb_master_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   m0_adr_i;
  logic [DW-1:0]   m0_dat_i;
  logic [DW/8-1:0] m0_sel_i;
  logic            m0_we_i;
  logic            m0_cyc_i;
  logic            m0_stb_i;
  logic [DW-1:0]   m0_dat_o;
  logic            m0_ack_o;
  logic            m0_err_o;

  logic [AW-1:0]   m1_adr_i;
  logic [DW-1:0]   m1_dat_i;
  logic [DW/8-1:0] m1_sel_i;
  logic            m1_we_i;
  logic            m1_cyc_i;
  logic            m1_stb_i;
  logic [DW-1:0]   m1_dat_o;
  logic            m1_ack_o;
  logic            m1_err_o;

  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW/8-1:0] s_sel_o;
  logic            s_we_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;
  logic [1:0]      gnt_o;

  modport slave (
    input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, gnt_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, gnt_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - two-master round-robin Wishbone arbiter with registered grant
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wb_master_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last_gnt, last_gnt_nxt;
  logic   req0, req1;
  logic   timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int             CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] stall_cnt;
  logic [1:0]    mask;
  logic          owner_cyc;

  assign owner_cyc = (state == GNT0) ? bus.m0_cyc_i :
                     (state == GNT1) ? bus.m1_cyc_i : 1'b0;
  assign timeout   = owner_cyc && (stall_cnt == TO_MAX);
  assign req0      = bus.m0_cyc_i && !mask[0];
  assign req1      = bus.m1_cyc_i && !mask[1];

  // A timed-out master stays masked until it has visibly dropped cyc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      mask      <= 2'b00;
    end else begin
      if (state == IDLE || state_nxt == IDLE || bus.s_ack_i)
        stall_cnt <= '0;
      else if (bus.s_stb_o)
        stall_cnt <= stall_cnt + 1'b1;

      if (timeout && state == GNT0)
        mask[0] <= 1'b1;
      else if (!bus.m0_cyc_i)
        mask[0] <= 1'b0;

      if (timeout && state == GNT1)
        mask[1] <= 1'b1;
      else if (!bus.m1_cyc_i)
        mask[1] <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign req0    = bus.m0_cyc_i;
  assign req1    = bus.m1_cyc_i;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    bus.gnt_o    = 2'b00;
    bus.s_adr_o  = AW'(0);
    bus.s_dat_o  = DW'(0);
    bus.s_sel_o  = (DW/8)'(0);
    bus.s_we_o   = 1'b0;
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.m0_ack_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_err_o = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the master that did not hold the bus last wins.
        if (req0 && (!req1 || last_gnt)) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (req1) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0: begin
        bus.gnt_o    = 2'b01;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_cyc_o  = bus.m0_cyc_i && !timeout;
        bus.s_stb_o  = bus.m0_cyc_i && bus.m0_stb_i && !timeout;
        bus.m0_ack_o = bus.s_ack_i && !timeout;
        bus.m0_err_o = timeout;
        if (!bus.m0_cyc_i || timeout)
          state_nxt = IDLE;
      end
      GNT1: begin
        bus.gnt_o    = 2'b10;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_cyc_o  = bus.m1_cyc_i && !timeout;
        bus.s_stb_o  = bus.m1_cyc_i && bus.m1_stb_i && !timeout;
        bus.m1_ack_o = bus.s_ack_i && !timeout;
        bus.m1_err_o = timeout;
        if (!bus.m1_cyc_i || timeout)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
